// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package inst_fetch_unit_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_REDIRECT = 2'd1,
        PC_INCR     = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - redirect, instruction memory and decode-side signals of the fetch unit
interface inst_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            imem_resp_err;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic            out_fault;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        output out_valid, out_inst, out_pc, out_fault,
        input  out_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        input  out_valid, out_inst, out_pc, out_fault,
        output out_ready
    );

endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - multicycle fetch stage, one outstanding imem request; IFU_ALIGN_CHECK_EN enables misaligned-pc faulting
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_fetch_unit_if.master fetch
);

    fetch_state_t      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              pend_q, pend_d;
    logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
    pc_sel_t           pc_sel;

    logic              out_valid_q, out_valid_d;
    logic [INST_W-1:0] out_inst_q, out_inst_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic              out_fault_q, out_fault_d;
    logic              req_valid_c;

    // A redirect arriving this cycle takes priority over an older pending one.
    logic              redirect_now;
    logic [XLEN-1:0]   redirect_tgt;

    assign redirect_now = fetch.redirect_valid | pend_q;
    assign redirect_tgt = fetch.redirect_valid ? fetch.redirect_pc : pend_pc_q;

    always_comb begin
        state_d     = state_q;
        pc_sel      = PC_HOLD;
        pend_d      = pend_q | fetch.redirect_valid;
        pend_pc_d   = fetch.redirect_valid ? fetch.redirect_pc : pend_pc_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_fault_d = out_fault_q;
        req_valid_c = 1'b0;

        case (state_q)
            REQ: begin
`ifdef IFU_ALIGN_CHECK_EN
                if (pc_q[1:0] != 2'b00) begin
                    state_d     = VALID;
                    out_valid_d = 1'b1;
                    out_inst_d  = '0;
                    out_pc_d    = pc_q;
                    out_fault_d = 1'b1;
                end else begin
                    req_valid_c = 1'b1;
                    if (fetch.imem_req_ready) state_d = WAIT;
                end
`else
                req_valid_c = 1'b1;
                if (fetch.imem_req_ready) state_d = WAIT;
`endif
            end

            WAIT: begin
                if (fetch.imem_resp_valid) begin
                    if (redirect_now) begin
                        pc_sel  = PC_REDIRECT;
                        pend_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        out_valid_d = 1'b1;
                        out_inst_d  = fetch.imem_resp_data;
                        out_pc_d    = pc_q;
                        out_fault_d = fetch.imem_resp_err;
                        state_d     = VALID;
                    end
                end
            end

            VALID: begin
                // Flush wins over both valid-stability and a same-cycle handshake.
                if (redirect_now) begin
                    pc_sel      = PC_REDIRECT;
                    pend_d      = 1'b0;
                    out_valid_d = 1'b0;
                    state_d     = REQ;
                end else if (fetch.out_ready) begin
                    pc_sel      = PC_INCR;
                    out_valid_d = 1'b0;
                    state_d     = REQ;
                end
            end

            default: state_d = REQ;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        case (pc_sel)
            PC_REDIRECT: pc_d = redirect_tgt;
            PC_INCR:     pc_d = pc_q + XLEN'(4);
            default:     pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            pend_q      <= 1'b0;
            pend_pc_q   <= '0;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
            out_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_pc_q   <= pend_pc_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            out_fault_q <= out_fault_d;
        end
    end

    // Request is decoded from state, masked while reset is held.
    assign fetch.imem_req_valid = rst_n & req_valid_c;
    assign fetch.imem_addr      = pc_q;
    assign fetch.out_valid      = out_valid_q;
    assign fetch.out_inst       = out_inst_q;
    assign fetch.out_pc         = out_pc_q;
    assign fetch.out_fault      = out_fault_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run = 0;
    int   tests_failed = 0;

    inst_fetch_unit_if #(.XLEN(32)) bus ();

    inst_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fetch (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch_word(input logic [31:0] data, input logic err);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = data;
        bus.imem_resp_err   = err;
        tick();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_err   = 1'b0;
        bus.imem_resp_data  = 32'h0;
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.imem_resp_err   = 1'b0;
        bus.out_ready       = 1'b0;

        tick();
        check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_inst", bus.out_inst, 32'h0);
        check_eq("rst_out_pc", bus.out_pc, 32'h0);
        check_eq("rst_out_fault", 32'(bus.out_fault), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check_eq("first_addr", bus.imem_addr, 32'h8000_0000);

        // zero-wait fetch, then backpressure
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        check_eq("wait_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h0010_0093;
        tick();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        check_eq("z_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("z_out_inst", bus.out_inst, 32'h0010_0093);
        check_eq("z_out_pc", bus.out_pc, 32'h8000_0000);
        check_eq("z_out_fault", 32'(bus.out_fault), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check_eq("bp_out_inst", bus.out_inst, 32'h0010_0093);
            check_eq("bp_out_pc", bus.out_pc, 32'h8000_0000);
            check_eq("bp_no_req", 32'(bus.imem_req_valid), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq("hs_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("hs_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check_eq("hs_next_addr", bus.imem_addr, 32'h8000_0004);

        // redirect during WAIT, response two cycles later is discarded
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0100;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h1111_1111;
        tick();
        bus.imem_resp_valid = 1'b0;
        check_eq("rw_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rw_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check_eq("rw_addr", bus.imem_addr, 32'h8000_0100);
        tick();
        check_eq("rw_hold_addr", bus.imem_addr, 32'h8000_0100);
        check_eq("rw_hold_valid", 32'(bus.out_valid), 32'd0);

        // redirect in REQ: request still completes, response discarded
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0010;
        bus.imem_req_ready = 1'b1;
        tick();
        bus.redirect_valid  = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h2222_2222;
        tick();
        bus.imem_resp_valid = 1'b0;
        check_eq("rq_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rq_addr", bus.imem_addr, 32'h8000_0010);

        // redirect colliding with out handshake
        fetch_word(32'h0000_0013, 1'b0);
        check_eq("hr_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("hr_out_pc", bus.out_pc, 32'h8000_0010);
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0200;
        tick();
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        check_eq("hr_flush_valid", 32'(bus.out_valid), 32'd0);
        check_eq("hr_addr", bus.imem_addr, 32'h8000_0200);

        // access fault passes data through
        fetch_word(32'hDEAD_BEEF, 1'b1);
        check_eq("err_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("err_fault", 32'(bus.out_fault), 32'd1);
        check_eq("err_inst", bus.out_inst, 32'hDEAD_BEEF);
        check_eq("err_pc", bus.out_pc, 32'h8000_0200);

        // redirect while VALID drops the instruction; then pc wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        check_eq("rv_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rv_addr", bus.imem_addr, 32'hFFFF_FFFC);
        fetch_word(32'h0000_0013, 1'b0);
        check_eq("wrap_out_pc", bus.out_pc, 32'hFFFF_FFFC);
        check_eq("wrap_fault", 32'(bus.out_fault), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq("wrap_addr", bus.imem_addr, 32'h0000_0000);
        check_eq("wrap_req_valid", 32'(bus.imem_req_valid), 32'd1);

        // reset mid-WAIT, then a stray response is ignored
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        #1;
        check_eq("mr_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("mr_out_valid", 32'(bus.out_valid), 32'd0);
        rst_n               = 1'b1;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h3333_3333;
        tick();
        bus.imem_resp_valid = 1'b0;
        check_eq("mr_stray_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mr_addr", bus.imem_addr, 32'h8000_0000);
        check_eq("mr_req_after", 32'(bus.imem_req_valid), 32'd1);

`ifdef IFU_ALIGN_CHECK_EN
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0002;
        bus.imem_req_ready = 1'b1;
        tick();
        bus.redirect_valid  = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        tick();
        bus.imem_resp_valid = 1'b0;
        check_eq("al_no_req", 32'(bus.imem_req_valid), 32'd0);
        tick();
        check_eq("al_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("al_fault", 32'(bus.out_fault), 32'd1);
        check_eq("al_inst", bus.out_inst, 32'h0);
        check_eq("al_pc", bus.out_pc, 32'h8000_0002);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
